// File: rtl/moore_input_conditioner.sv
`default_nettype none
// ============================================================================
// moore_input_conditioner
// Synchronises and debounces the serial-data and step pins and turns each
// debounced step press into a one-cycle bit strobe with shift history/count.
// Revision: 1.0
// ============================================================================
module moore_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       din_raw,
    input  logic       step_raw,
    output logic       bit_valid,
    output logic       bit_out,
    output logic [7:0] history,
    output logic [7:0] bit_count,
    output logic       din_db,
    output logic       step_db
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Lane 0 carries the data pin, lane 1 the step button.
    logic [1:0] raw_w;
    logic [1:0] s1_q;
    logic [1:0] s2_q;
    logic [1:0] stable_w;

    assign raw_w = {step_raw, din_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= raw_w;
            s2_q <= s1_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             stable_q;
        logic             stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (s2_q[gi] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = s2_q[gi];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_w[gi] = stable_q;
    end

    logic       step_prev_q;
    logic       bit_valid_q;
    logic       bit_valid_d;
    logic       bit_out_q;
    logic       bit_out_d;
    logic [7:0] history_q;
    logic [7:0] history_d;
    logic [7:0] bit_count_q;
    logic [7:0] bit_count_d;
    logic       rise_w;

    assign rise_w = stable_w[1] & ~step_prev_q;

    // A rise seen while disabled is simply dropped, never queued.
    always_comb begin
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
        history_d   = history_q;
        bit_count_d = bit_count_q;
        if (rise_w && ena) begin
            bit_valid_d = 1'b1;
            bit_out_d   = stable_w[0];
            history_d   = {history_q[6:0], stable_w[0]};
            bit_count_d = bit_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev_q <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            history_q   <= 8'h00;
            bit_count_q <= 8'h00;
        end else begin
            step_prev_q <= stable_w[1];
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            history_q   <= history_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign history   = history_q;
    assign bit_count = bit_count_q;
    assign din_db    = stable_w[0];
    assign step_db   = stable_w[1];

endmodule
`default_nettype wire

// File: tb/tb_moore_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_moore_input_conditioner
// Directed stimulus checked every cycle against a window-based reference model.
// Revision: 1.0
// ============================================================================
module tb_moore_input_conditioner;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       din_raw = 1'b0;
    logic       step_raw = 1'b0;
    logic       bit_valid;
    logic       bit_out;
    logic [7:0] history;
    logic [7:0] bit_count;
    logic       din_db;
    logic       step_db;

    int n_pass   = 0;
    int n_total  = 0;
    int n_strobe = 0;
    bit chk_en   = 1'b0;

    moore_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din_raw   (din_raw),
        .step_raw  (step_raw),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .history   (history),
        .bit_count (bit_count),
        .din_db    (din_db),
        .step_db   (step_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a level is accepted once the last N synchronised
    // samples all disagree with the currently accepted level.
    logic [1:0] m_s1;
    logic [7:0] m_win [2];
    logic [1:0] m_stable;
    logic       m_prev;
    logic       m_valid;
    logic       m_bit;
    logic [7:0] m_hist;
    logic [7:0] m_cnt;

    function automatic logic all_differ(input logic [7:0] win, input logic lvl);
        for (int k = 0; k < N; k++)
            if (win[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1     <= 2'b00;
            m_win[0] <= 8'h00;
            m_win[1] <= 8'h00;
            m_stable <= 2'b00;
            m_prev   <= 1'b0;
            m_valid  <= 1'b0;
            m_bit    <= 1'b0;
            m_hist   <= 8'h00;
            m_cnt    <= 8'h00;
        end else begin
            m_s1 <= {step_raw, din_raw};
            for (int i = 0; i < 2; i++) begin
                m_win[i] <= {m_win[i][6:0], m_s1[i]};
                if (all_differ(m_win[i], m_stable[i])) m_stable[i] <= ~m_stable[i];
            end
            m_prev  <= m_stable[1];
            m_valid <= m_stable[1] & ~m_prev & ena;
            if (m_stable[1] & ~m_prev & ena) begin
                m_bit  <= m_stable[0];
                m_hist <= {m_hist[6:0], m_stable[0]};
                m_cnt  <= m_cnt + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model bit_valid", {7'd0, bit_valid}, {7'd0, m_valid});
            check("model bit_out",   {7'd0, bit_out},   {7'd0, m_bit});
            check("model history",   history,           m_hist);
            check("model bit_count", bit_count,         m_cnt);
            check("model din_db",    {7'd0, din_db},    {7'd0, m_stable[0]});
            check("model step_db",   {7'd0, step_db},   {7'd0, m_stable[1]});
        end
    end

    always @(negedge clk) if (bit_valid) n_strobe <= n_strobe + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic d, input int hi, input int lo);
        @(negedge clk);
        din_raw = d;
        cycles(12);
        step_raw = 1'b1;
        cycles(hi);
        step_raw = 1'b0;
        cycles(lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bit_valid"}, {7'd0, bit_valid}, 8'd0);
        check({tag, " bit_out"},   {7'd0, bit_out},   8'd0);
        check({tag, " history"},   history,           8'd0);
        check({tag, " bit_count"}, bit_count,         8'd0);
        check({tag, " din_db"},    {7'd0, din_db},    8'd0);
        check({tag, " step_db"},   {7'd0, step_db},   8'd0);
    endtask

    initial begin
        int s0;
        logic seen;

        // Reset with inputs toggling
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din_raw  = i[0];
            step_raw = i[1];
        end
        @(negedge clk);
        check_all_zero("reset");
        din_raw = 1'b0;
        step_raw = 1'b0;
        #2 rst_n = 1'b1;
        cycles(20);
        check("idle strobes", 8'(n_strobe), 8'd0);
        check("idle history", history, 8'h00);

        // Clean press: strobe exactly after edge 3+N
        @(negedge clk);
        din_raw = 1'b1;
        cycles(12);
        step_raw = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("press edge6 valid", {7'd0, bit_valid}, 8'd0);
        @(posedge clk);
        #1 check("press edge7 valid", {7'd0, bit_valid}, 8'd1);
        check("press bit_out", {7'd0, bit_out}, 8'd1);
        check("press history", history, 8'h01);
        check("press count", bit_count, 8'd1);
        @(posedge clk);
        #1 check("press edge8 valid", {7'd0, bit_valid}, 8'd0);
        cycles(12);
        step_raw = 1'b0;
        cycles(20);
        check("release strobes", 8'(n_strobe), 8'd1);

        // Glitch rejection: 3 cycles dropped, 4 cycles accepted
        step_raw = 1'b1;
        cycles(3);
        step_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= step_db;
        end
        check("glitch3 step_db", {7'd0, seen}, 8'd0);
        check("glitch3 strobes", 8'(n_strobe), 8'd1);
        step_raw = 1'b1;
        cycles(4);
        step_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= step_db;
        end
        check("pulse4 step_db", {7'd0, seen}, 8'd1);
        check("pulse4 strobes", 8'(n_strobe), 8'd2);
        check("pulse4 history", history, 8'h03);

        // Bit sequence 1,0,1,1 from a fresh reset, then wrap at 256
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("seq reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        press(1'b1, 12, 12);
        press(1'b0, 12, 12);
        press(1'b1, 12, 12);
        press(1'b1, 12, 12);
        check("seq history", history, 8'h0B);
        check("seq count", bit_count, 8'd4);
        for (int i = 0; i < 252; i++) press(1'(i % 3 == 0), 8, 8);
        check("wrap count", bit_count, 8'd0);

        // Enable gating
        s0 = n_strobe;
        ena = 1'b0;
        press(1'b1, 12, 12);
        check("ena0 strobes", 8'(n_strobe - s0), 8'd0);
        check("ena0 count", bit_count, 8'd0);
        step_raw = 1'b1;
        cycles(12);
        ena = 1'b1;
        cycles(12);
        check("ena raised held", 8'(n_strobe - s0), 8'd0);
        step_raw = 1'b0;
        cycles(12);
        press(1'b0, 12, 12);
        check("ena next press", 8'(n_strobe - s0), 8'd1);
        check("ena next count", bit_count, 8'd1);

        // Reset at edge 5 of a press, released with step still high
        @(negedge clk);
        din_raw = 1'b1;
        cycles(12);
        step_raw = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid reset");
        cycles(2);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("post-reset edge6 valid", {7'd0, bit_valid}, 8'd0);
        @(posedge clk);
        #1 check("post-reset edge7 valid", {7'd0, bit_valid}, 8'd1);
        check("post-reset count", bit_count, 8'd1);
        check("post-reset bit_out", {7'd0, bit_out}, 8'd1);
        step_raw = 1'b0;
        cycles(12);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
